// File: rtl/counter_report_tx.sv
// counter_report_tx
//
// Purpose:
//   Reports a counter value as ASCII decimal text over a simple byte
//   transmitter handshake. On a report request the current counter value is
//   clamped to MAX_VAL, converted to four BCD digits with a sequential
//   shift-add-3 (double dabble) converter, and sent as thousands, hundreds,
//   tens, ones, keeping leading zeros.
//
// Configuration macro:
//   REPORT_CRLF_EN - when defined, a CR (0x0D) and LF (0x0A) follow the ones
//                    digit, giving 6 bytes per report. When undefined, exactly
//                    4 bytes are sent and no CR/LF logic exists.
//
// Parameters:
//   MAX_VAL     largest reportable value; larger counter values are clamped
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   rst         asynchronous active-high reset
//   counter     [13:0] live counter value to report
//   report_req  single-cycle request to report the current counter value
//   tx_busy     transmitter busy, no new byte may start while high
//   tx_done     single-cycle pulse when the transmitter finishes a byte
//   tx_data     [7:0] ASCII byte offered to the transmitter
//   tx_start    single-cycle start pulse qualifying tx_data
//   busy        high from request acceptance until the last byte's tx_done

module counter_report_tx #(
  parameter int MAX_VAL = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] counter,
  input  logic        report_req,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

`ifdef REPORT_CRLF_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  localparam logic [13:0] MAX_CLAMP = 14'(MAX_VAL);
  localparam logic [3:0]  LAST_BIT  = 4'd13;

  logic [1:0]  state;
  logic [13:0] shift_reg;
  logic [15:0] bcd;
  logic [3:0]  bit_cnt;
  logic [2:0]  byte_idx;

  logic [13:0] clamped;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_next;
  logic [7:0]  next_byte;

  // Clamp the live counter so the report never exceeds four decimal digits.
  always_comb begin
    clamped = counter;
    if (counter > MAX_CLAMP) begin
      clamped = MAX_CLAMP;
    end
  end

  // One double-dabble step: every BCD digit of 5 or more gets 3 added before
  // the shift, so the digit carries correctly into the next decade once
  // doubled. The next binary bit enters at the bottom of the ones digit.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < 4; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
    bcd_next = (bcd_adj << 1) | {15'd0, shift_reg[13]};
  end

  // Select the byte for the current index. Digits are at most 9, so the
  // ASCII code is simply the digit with 0x3 in the upper nibble.
  always_comb begin
    next_byte = 8'h00;
    case (byte_idx)
      3'd0:    next_byte = {4'h3, bcd[15:12]};
      3'd1:    next_byte = {4'h3, bcd[11:8]};
      3'd2:    next_byte = {4'h3, bcd[7:4]};
      3'd3:    next_byte = {4'h3, bcd[3:0]};
`ifdef REPORT_CRLF_EN
      3'd4:    next_byte = 8'h0D;
      3'd5:    next_byte = 8'h0A;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  // Report sequencer. tx_start defaults low each cycle so it can only ever
  // be a single-cycle pulse. tx_data is written only when a byte starts, so
  // it holds steady while the transmitter works on it. Requests outside IDLE
  // and tx_done outside WAIT fall through the case untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= 14'd0;
      bcd       <= 16'd0;
      bit_cnt   <= 4'd0;
      byte_idx  <= 3'd0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (report_req) begin
            shift_reg <= clamped;
            bcd       <= 16'd0;
            bit_cnt   <= 4'd0;
            byte_idx  <= 3'd0;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          bcd       <= bcd_next;
          shift_reg <= {shift_reg[12:0], 1'b0};
          bit_cnt   <= bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= next_byte;
            tx_start <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx <= 3'd0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_report_tx.sv
// tb_counter_report_tx
//
// Self-checking bench for counter_report_tx. Each report request pushes the
// expected ASCII bytes (computed arithmetically from the requested value) into
// a queue; a transmitter model pops and compares one entry on every tx_start
// and answers each start with a tx_done ten cycles later.
// Define REPORT_CRLF_EN for both files to exercise the CR/LF build.

module tb_counter_report_tx;

`ifdef REPORT_CRLF_EN
  localparam int BYTES = 6;
`else
  localparam int BYTES = 4;
`endif
  localparam int CLAMP = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] counter = 14'd0;
  logic        report_req = 1'b0;
  logic        tx_busy = 1'b0;
  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;

  assign tx_done = model_done | stray_done;

  counter_report_tx #(.MAX_VAL(CLAMP)) dut (
    .clk        (clk),
    .rst        (rst),
    .counter    (counter),
    .report_req (report_req),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int starts = 0;
  int first_start_cyc = 0;
  int req_cyc = 0;
  int busy_falls = 0;
  int done_timer = 0;
  logic [7:0] cur_byte = 8'h00;
  logic prev_busy = 1'b0;
  logic prev_start = 1'b0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expected bytes for one report, built with decimal arithmetic.
  task automatic pushReport(input int value);
    int v;
    v = (value > CLAMP) ? CLAMP : value;
    exp_q.push_back(8'h30 + 8'((v / 1000) % 10));
    exp_q.push_back(8'h30 + 8'((v / 100) % 10));
    exp_q.push_back(8'h30 + 8'((v / 10) % 10));
    exp_q.push_back(8'h30 + 8'(v % 10));
`ifdef REPORT_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Pulses report_req for one cycle with the given counter value and records
  // the cycle number of the edge that samples it.
  task automatic applyStimulus(input int value);
    @(negedge clk);
    counter    = 14'(value);
    report_req = 1'b1;
    starts     = 0;
    busy_falls = 0;
    pushReport(value);
    @(negedge clk);
    report_req = 1'b0;
    req_cyc    = cyc;
  endtask

  task automatic waitReportDone();
    for (int i = 0; i < 600 && busy; i++) @(negedge clk);
    checkOutput("report_done", busy, 0);
  endtask

  // Transmitter model and scoreboard consumer, sampled 1 time unit after
  // each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (model_done && !rst) checkOutput("data_stable", tx_data, cur_byte);
    model_done = 1'b0;
    if (rst) begin
      done_timer = 0;
    end else begin
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) model_done = 1'b1;
      end
      if (tx_start && prev_start) checkOutput("start_single_cycle", 1, 0);
      if (tx_start && !prev_start) begin
        if (starts == 0) first_start_cyc = cyc;
        starts++;
        done_timer = 10;
        cur_byte   = tx_data;
        if (exp_q.size() == 0) checkOutput("spurious_start", 1, 0);
        else checkOutput("byte", tx_data, exp_q.pop_front());
      end
    end
    if (prev_busy && !busy) busy_falls++;
    prev_busy  = busy;
    prev_start = tx_start;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int values[3];
    values = '{0, 12000, 9999};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_tx_start", tx_start, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Basic report and first-start latency. The sampling edge counts as
    // the latch cycle; 14 conversion edges and the SEND edge follow, so
    // tx_start is first seen 15 edges after it (in the 16th cycle).
    applyStimulus(1234);
    waitReportDone();
    checkOutput("first_start_latency", first_start_cyc - req_cyc, 15);
    checkOutput("bytes_1234", starts, BYTES);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("busy_falls_1234", busy_falls, 1);

    // Zero, clamp and maximum
    foreach (values[k]) begin
      applyStimulus(values[k]);
      waitReportDone();
      checkOutput("bytes_value", starts, BYTES);
    end

    // Requests while busy are ignored
    applyStimulus(1234);
    repeat (5) @(negedge clk);
    counter = 14'd5678;
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    repeat (30) @(negedge clk);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    waitReportDone();
    repeat (40) @(negedge clk);
    checkOutput("double_req_bytes", starts, BYTES);
    checkOutput("double_req_busy_falls", busy_falls, 1);

    // Transmitter busy holds the first byte for 50 cycles in SEND
    tx_busy = 1'b1;
    applyStimulus(1234);
    repeat (64) @(negedge clk);
    checkOutput("no_start_while_tx_busy", starts, 0);
    tx_busy = 1'b0;
    waitReportDone();
    checkOutput("bytes_after_tx_busy", starts, BYTES);

    // tx_done outside WAIT is ignored (IDLE and CONV)
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    checkOutput("stray_done_idle_busy", busy, 0);
    applyStimulus(4321);
    repeat (3) @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    waitReportDone();
    checkOutput("bytes_stray_done", starts, BYTES);

    // Counter changes during conversion do not affect the report
    applyStimulus(1234);
    repeat (3) @(negedge clk);
    counter = 14'd5678;
    waitReportDone();
    checkOutput("bytes_counter_change", starts, BYTES);

    // Request coinciding with the final tx_done is ignored
    applyStimulus(8765);
    for (int i = 0; i < 600 && !(model_done && starts == BYTES); i++) @(negedge clk);
    checkOutput("final_done_seen", model_done, 1);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    checkOutput("busy_after_final_done", busy, 0);
    repeat (40) @(negedge clk);
    checkOutput("req_at_final_done_ignored", starts, BYTES);
    checkOutput("busy_stays_low", busy, 0);

    // Reset after the second byte aborts the report
    applyStimulus(1234);
    for (int i = 0; i < 600 && starts < 2; i++) @(negedge clk);
    checkOutput("second_start_seen", starts, 2);
    rst = 1'b1;
    #1;
    checkOutput("abort_tx_start", tx_start, 0);
    checkOutput("abort_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("no_bytes_after_reset", starts, 2);
    applyStimulus(42);
    waitReportDone();
    checkOutput("bytes_0042", starts, BYTES);
    checkOutput("queue_drained_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/counter_report_tx.md
COUNTER_REPORT_TX -- requirements
Module: counter_report_tx

Interface
REQ-001 SHALL have parameter MAX_VAL, default 9999, meaning the largest reportable value; larger inputs are clamped to it.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port counter  input  14  live counter value to report.
REQ-005 SHALL have port report_req  input  1  single-cycle request to transmit the current counter value.
REQ-006 SHALL have port tx_busy  input  1  byte transmitter busy; high means no new byte may start.
REQ-007 SHALL have port tx_done  input  1  single-cycle pulse when the transmitter finishes a byte.
REQ-008 SHALL have port tx_data  output  8  ASCII byte offered to the transmitter.
REQ-009 SHALL have port tx_start  output  1  single-cycle start pulse qualifying tx_data.
REQ-010 SHALL have port busy  output  1  high from acceptance of report_req until the last byte's tx_done.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, SEND and WAIT.
REQ-012 IDLE: SHALL latch min(counter, MAX_VAL) when report_req=1 and go to CONV; report_req in any other state SHALL be ignored, with no queuing.
REQ-013 CONV: SHALL convert the latched 14-bit value to 4 BCD digits with sequential shift-add-3, one bit per cycle, for exactly 14 cycles, then go to SEND.
REQ-014 SEND: when tx_busy=0, SHALL drive tx_data = 0x30 + digit and pulse tx_start for exactly one cycle, then go to WAIT; while tx_busy=1, SHALL hold tx_start=0.
REQ-015 WAIT: on tx_done=1, SHALL advance the byte index and go to SEND if bytes remain, else to IDLE.
REQ-016 Byte order SHALL be thousands, hundreds, tens, ones, with leading zeros transmitted (0 -> "0000").
REQ-017 tx_data SHALL remain stable from the tx_start cycle until the matching tx_done.
REQ-018 With tx_busy=0, the first tx_start SHALL occur 16 clk cycles after the edge that samples report_req: 1 latch cycle + 14 CONV cycles + 1 SEND cycle.
REQ-019 Changes on counter after the latch SHALL NOT affect the report in progress.
REQ-020 A report_req arriving in the same cycle as the final tx_done SHALL be ignored; busy SHALL fall in the cycle after the final tx_done.
REQ-021 A tx_done arriving in any state other than WAIT SHALL be ignored.

Reset
REQ-022 While rst=1, SHALL set: state=IDLE, tx_start=0, tx_data=8'h00, busy=0, byte index=0, BCD and shift registers=0.
REQ-023 Assertion of rst mid-conversion or mid-send SHALL abort the report immediately; no further tx_start SHALL occur until a new report_req after rst deasserts.

Configuration
REQ-024 Macro REPORT_CRLF_EN defined: after the ones digit, SHALL send 0x0D then 0x0A, giving 6 bytes per report.
REQ-025 Macro REPORT_CRLF_EN undefined: SHALL send exactly 4 bytes per report, and no CR/LF logic SHALL be synthesized.

Verification
REQ-026 counter=1234, report_req pulse, transmitter model with tx_busy=0 and tx_done 10 cycles after each start -> bytes 0x31 0x32 0x33 0x34 (+0x0D 0x0A with REPORT_CRLF_EN); first tx_start 16 cycles after the request.
REQ-027 counter=0 -> "0000"; counter=12000 -> "9999" (clamp); counter=9999 -> "9999".
REQ-028 Second report_req issued during busy=1 -> exactly one report (4 or 6 tx_start pulses), busy drops once.
REQ-029 tx_busy held high for 50 cycles at the first SEND -> tx_start stays 0 for those 50 cycles, then pulses once with 0x31.
REQ-030 rst asserted after the 2nd tx_start -> tx_start=0, busy=0 immediately; no further bytes; a new report_req with counter=0042 -> "0042".
REQ-031 counter changed 1234 -> 5678 during CONV -> transmitted bytes are "1234".
